// File: rtl/dmem_pkg.sv
// rtl/dmem_pkg.sv - shared types and constants for the data-memory responder
package dmem_pkg;

    typedef enum logic [2:0] {
        XFER_BYTE   = 3'b000,
        XFER_HALF   = 3'b001,
        XFER_WORD   = 3'b010,
        XFER_BYTE_U = 3'b100,
        XFER_HALF_U = 3'b101
    } xfer_size_e;

    localparam logic [3:0] LANE_MASK_BYTE = 4'b0001;
    localparam logic [3:0] LANE_MASK_HALF = 4'b0011;
    localparam logic [3:0] LANE_MASK_WORD = 4'b1111;

    typedef enum logic {
        ST_OK,
        ST_FAULT
    } err_state_e;

    function automatic logic xfer_legal(input logic [2:0] size);
        case (size)
            XFER_BYTE, XFER_HALF, XFER_WORD, XFER_BYTE_U, XFER_HALF_U: xfer_legal = 1'b1;
            default:                                                   xfer_legal = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// rtl/dmem_lane_align.sv - store lane masking/shifting and load extraction/extension
module dmem_lane_align
    import dmem_pkg::*;
(
    input  logic [2:0]  xfer_size,
    input  logic [1:0]  byte_off,
    input  logic [31:0] store_data,
    input  logic [31:0] mem_word,
    output logic [3:0]  byte_en,
    output logic [31:0] store_word,
    output logic [31:0] load_data
);

    logic [3:0]  lane_mask;
    logic [31:0] shifted;

    always_comb begin
        lane_mask  = 4'b0000;
        load_data  = 32'h0;
        shifted    = mem_word >> {byte_off, 3'b000};
        store_word = store_data << {byte_off, 3'b000};
        case (xfer_size_e'(xfer_size))
            XFER_BYTE: begin
                lane_mask = LANE_MASK_BYTE;
                load_data = {{24{shifted[7]}}, shifted[7:0]};
            end
            XFER_BYTE_U: begin
                lane_mask = LANE_MASK_BYTE;
                load_data = {24'h0, shifted[7:0]};
            end
            XFER_HALF: begin
                lane_mask = LANE_MASK_HALF;
                load_data = {{16{shifted[15]}}, shifted[15:0]};
            end
            XFER_HALF_U: begin
                lane_mask = LANE_MASK_HALF;
                load_data = {16'h0, shifted[15:0]};
            end
            XFER_WORD: begin
                lane_mask = LANE_MASK_WORD;
                load_data = mem_word;
            end
            default: begin
                lane_mask = 4'b0000;
                load_data = 32'h0;
            end
        endcase
        byte_en = lane_mask << byte_off;
    end

endmodule

// File: rtl/dmem_responder.sv
// rtl/dmem_responder.sv - single-cycle data memory with sticky error capture
// DMEM_MISALIGN_TRAP_EN: defined traps misaligned half/word accesses, undefined aligns them silently.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
    input  logic        CLK,
    input  logic        rst,
    input  logic [31:0] address,
    input  logic        write_enable,
    input  logic        read_enable,
    input  logic [31:0] write_data,
    input  logic [2:0]  xfer_size,
    output logic [31:0] read_data,
    output logic        rd_valid,
    output logic        access_err,
    output logic [31:0] err_addr
);

    localparam int unsigned IDX_W = $clog2(DEPTH_WORDS);
    localparam logic [32:0] SPAN  = 33'(DEPTH_WORDS) << 2;

    logic [31:0] mem_q [DEPTH_WORDS];

    logic [31:0] read_data_q, read_data_d;
    logic        rd_valid_q, rd_valid_d;
    logic [31:0] err_addr_q, err_addr_d;
    err_state_e  state_q, state_d;

    logic [32:0]      offset;
    logic [IDX_W-1:0] word_idx;
    logic             in_range, size_ok, is_half, is_word;
    logic             misalign_err, bad_access, both_en, fault;
    logic             do_store, do_load;
    logic [1:0]       byte_off;
    logic [3:0]       byte_en;
    logic [31:0]      store_word, load_data, mem_rd_word;

    // 33-bit subtraction so addresses below BASE_ADDR show up as a borrow
    assign offset   = {1'b0, address} - {1'b0, BASE_ADDR};
    assign in_range = !offset[32] && (offset < SPAN);
    assign word_idx = offset[IDX_W+1:2];
    assign size_ok  = xfer_legal(xfer_size);
    assign is_half  = (xfer_size[1:0] == 2'b01);
    assign is_word  = (xfer_size == XFER_WORD);

`ifdef DMEM_MISALIGN_TRAP_EN
    logic misaligned;
    assign misaligned   = (is_half && address[0]) || (is_word && (address[1:0] != 2'b00));
    assign misalign_err = misaligned;
    assign byte_off     = address[1:0];
`else
    assign misalign_err = 1'b0;
    assign byte_off     = is_word ? 2'b00 : (is_half ? {address[1], 1'b0} : address[1:0]);
`endif

    assign bad_access = !in_range || !size_ok || misalign_err;
    assign both_en    = write_enable && read_enable;
    assign fault      = (write_enable || read_enable) && (both_en || bad_access);
    assign do_store   = write_enable && !read_enable && !bad_access && !rst;
    assign do_load    = read_enable && !write_enable && !rst;

    assign mem_rd_word = mem_q[word_idx];

    dmem_lane_align u_lane_align (
        .xfer_size  (xfer_size),
        .byte_off   (byte_off),
        .store_data (write_data),
        .mem_word   (mem_rd_word),
        .byte_en    (byte_en),
        .store_word (store_word),
        .load_data  (load_data)
    );

    // Storage is deliberately outside the reset domain
    always_ff @(posedge CLK) begin
        if (do_store) begin
            for (int i = 0; i < 4; i++) begin
                if (byte_en[i]) begin
                    mem_q[word_idx][8*i +: 8] <= store_word[8*i +: 8];
                end
            end
        end
    end

    always_comb begin
        read_data_d = read_data_q;
        rd_valid_d  = 1'b0;
        if (do_load) begin
            rd_valid_d  = 1'b1;
            read_data_d = bad_access ? 32'h0 : load_data;
        end
    end

    always_comb begin
        state_d    = state_q;
        err_addr_d = err_addr_q;
        case (state_q)
            ST_OK: begin
                if (fault) begin
                    state_d    = ST_FAULT;
                    err_addr_d = address;
                end
            end
            ST_FAULT: state_d = ST_FAULT;
            default:  state_d = ST_OK;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (rst) begin
            read_data_q <= 32'h0;
            rd_valid_q  <= 1'b0;
            err_addr_q  <= 32'h0;
            state_q     <= ST_OK;
        end else begin
            read_data_q <= read_data_d;
            rd_valid_q  <= rd_valid_d;
            err_addr_q  <= err_addr_d;
            state_q     <= state_d;
        end
    end

    assign read_data  = read_data_q;
    assign rd_valid   = rd_valid_q;
    assign err_addr   = err_addr_q;
    assign access_err = (state_q == ST_FAULT);

endmodule

// File: tb/tb_dmem_responder.sv
// tb/tb_dmem_responder.sv - directed self-checking bench for dmem_responder
module tb_dmem_responder;

    logic        CLK = 1'b0;
    logic        rst;
    logic [31:0] address;
    logic        write_enable;
    logic        read_enable;
    logic [31:0] write_data;
    logic [2:0]  xfer_size;
    logic [31:0] read_data;
    logic        rd_valid;
    logic        access_err;
    logic [31:0] err_addr;

    int checks   = 0;
    int failures = 0;

    dmem_responder dut (
        .CLK          (CLK),
        .rst          (rst),
        .address      (address),
        .write_enable (write_enable),
        .read_enable  (read_enable),
        .write_data   (write_data),
        .xfer_size    (xfer_size),
        .read_data    (read_data),
        .rd_valid     (rd_valid),
        .access_err   (access_err),
        .err_addr     (err_addr)
    );

    always #5 CLK = ~CLK;

    task automatic drive(input logic we, input logic re, input logic [31:0] a,
                         input logic [31:0] d, input logic [2:0] sz);
        write_enable = we;
        read_enable  = re;
        address      = a;
        write_data   = d;
        xfer_size    = sz;
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        rst = 1'b1;
        drive(1'b0, 1'b0, 32'h0, 32'h0, 3'b010);
        tick();
        tick();
        chk("reset_read_data", read_data, 32'h0);
        chk("reset_rd_valid", {31'h0, rd_valid}, 32'h0);
        chk("reset_access_err", {31'h0, access_err}, 32'h0);
        chk("reset_err_addr", err_addr, 32'h0);

        rst = 1'b0;
        drive(1'b1, 1'b0, 32'h10, 32'hDEADBEEF, 3'b010); tick();
        chk("store_no_valid", {31'h0, rd_valid}, 32'h0);
        drive(1'b0, 1'b1, 32'h10, 32'h0, 3'b010); tick();
        chk("load_word_data", read_data, 32'hDEADBEEF);
        chk("load_word_valid", {31'h0, rd_valid}, 32'h1);
        drive(1'b0, 1'b0, 32'h0, 32'h0, 3'b010); tick();
        chk("idle_valid_low", {31'h0, rd_valid}, 32'h0);
        chk("idle_data_hold", read_data, 32'hDEADBEEF);

        drive(1'b0, 1'b1, 32'h13, 32'h0, 3'b000); tick();
        chk("lb_0x13", read_data, 32'hFFFFFFDE);
        drive(1'b0, 1'b1, 32'h13, 32'h0, 3'b100); tick();
        chk("lbu_0x13", read_data, 32'h000000DE);
        drive(1'b0, 1'b1, 32'h10, 32'h0, 3'b001); tick();
        chk("lh_0x10", read_data, 32'hFFFFBEEF);
        drive(1'b0, 1'b1, 32'h12, 32'h0, 3'b101); tick();
        chk("lhu_0x12", read_data, 32'h0000DEAD);
        drive(1'b0, 1'b1, 32'h11, 32'h0, 3'b100); tick();
        chk("lbu_0x11", read_data, 32'h000000BE);

        drive(1'b1, 1'b0, 32'h11, 32'hFFFFFF5A, 3'b000); tick();
        drive(1'b0, 1'b1, 32'h10, 32'h0, 3'b010); tick();
        chk("sb_then_lw", read_data, 32'hDEAD5AEF);

        drive(1'b1, 1'b0, 32'h20, 32'h11223344, 3'b010); tick();
        drive(1'b1, 1'b0, 32'h22, 32'h5555ABCD, 3'b101); tick();
        drive(1'b0, 1'b1, 32'h20, 32'h0, 3'b010); tick();
        chk("sh_upper_lw", read_data, 32'hABCD3344);
        chk("no_err_yet", {31'h0, access_err}, 32'h0);

        drive(1'b1, 1'b1, 32'h20, 32'h0, 3'b010); tick();
        chk("both_en_no_valid", {31'h0, rd_valid}, 32'h0);
        chk("both_en_err", {31'h0, access_err}, 32'h1);
        chk("both_en_err_addr", err_addr, 32'h20);
        drive(1'b0, 1'b1, 32'h20, 32'h0, 3'b010); tick();
        chk("both_en_no_store", read_data, 32'hABCD3344);

        rst = 1'b1;
        drive(1'b1, 1'b0, 32'h20, 32'hFFFFFFFF, 3'b010); tick();
        chk("rst_store_read_data", read_data, 32'h0);
        chk("rst_store_valid", {31'h0, rd_valid}, 32'h0);
        chk("rst_store_err", {31'h0, access_err}, 32'h0);
        chk("rst_store_err_addr", err_addr, 32'h0);
        drive(1'b0, 1'b1, 32'h20, 32'h0, 3'b010); tick();
        chk("rst_load_no_valid", {31'h0, rd_valid}, 32'h0);
        rst = 1'b0;
        drive(1'b0, 1'b1, 32'h20, 32'h0, 3'b010); tick();
        chk("rst_word_kept", read_data, 32'hABCD3344);

        drive(1'b0, 1'b1, 32'h1000, 32'h0, 3'b010); tick();
        chk("oob_read_data", read_data, 32'h0);
        chk("oob_rd_valid", {31'h0, rd_valid}, 32'h1);
        chk("oob_access_err", {31'h0, access_err}, 32'h1);
        chk("oob_err_addr", err_addr, 32'h1000);
        drive(1'b0, 1'b1, 32'h8, 32'h0, 3'b011); tick();
        chk("illegal_sz_data", read_data, 32'h0);
        chk("illegal_sz_valid", {31'h0, rd_valid}, 32'h1);
        chk("err_addr_sticky", err_addr, 32'h1000);
        drive(1'b1, 1'b0, 32'h1010, 32'h0, 3'b010); tick();
        drive(1'b0, 1'b1, 32'h10, 32'h0, 3'b010); tick();
        chk("oob_store_suppressed", read_data, 32'hDEAD5AEF);
        chk("err_still_set", {31'h0, access_err}, 32'h1);

        rst = 1'b1;
        drive(1'b0, 1'b0, 32'h0, 32'h0, 3'b010); tick();
        rst = 1'b0;
        drive(1'b0, 1'b1, 32'h11, 32'h0, 3'b001); tick();
`ifdef DMEM_MISALIGN_TRAP_EN
        chk("misalign_lh_data", read_data, 32'h0);
        chk("misalign_lh_err", {31'h0, access_err}, 32'h1);
        chk("misalign_lh_addr", err_addr, 32'h11);
        drive(1'b1, 1'b0, 32'h23, 32'h55667788, 3'b010); tick();
        drive(1'b0, 1'b1, 32'h20, 32'h0, 3'b010); tick();
        chk("misalign_sw_suppressed", read_data, 32'hABCD3344);
`else
        chk("misalign_lh_data", read_data, 32'h00005AEF);
        chk("misalign_lh_err", {31'h0, access_err}, 32'h0);
        drive(1'b1, 1'b0, 32'h23, 32'h55667788, 3'b010); tick();
        drive(1'b0, 1'b1, 32'h20, 32'h0, 3'b010); tick();
        chk("misalign_sw_aligned", read_data, 32'h55667788);
        chk("misalign_no_err", {31'h0, access_err}, 32'h0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
